// File: rtl/msmouse_pkg.sv
// Shared definitions for the Microsoft serial-mouse decoder: protocol constants,
// FSM state encodings and the parallel report layout.
package msmouse_pkg;

   localparam logic [6:0] MS_ID_CHAR  = 7'h4D;
   localparam int         MS_SYNC_BIT = 6;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_e;

   typedef enum logic [1:0] {
      P_B1 = 2'd0,
      P_B2 = 2'd1,
      P_B3 = 2'd2
   } asm_state_e;

   typedef struct packed {
      logic       btn_l;
      logic       btn_r;
      logic [7:0] dx;
      logic [7:0] dy;
   } report_t;

   // The sync bit marks the first byte of every packet, including the ID byte.
   function automatic logic is_first_byte(input logic [6:0] c);
      return c[MS_SYNC_BIT];
   endfunction

endpackage

// File: rtl/msmouse_serial_decoder_uart7n1_rx.sv
// 7N1 UART receiver: 2-flop input synchroniser, mid-bit sampling and stop-bit check.
// Delivers each good character as a one-cycle char_valid_o strobe.
module uart7n1_rx
   import msmouse_pkg::*;
#(
   parameter int CLKFREQ = 50_000_000,
   parameter int BAUD    = 1_200
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rd_i,
   output logic [6:0] char_o,
   output logic       char_valid_o,
   output logic       frame_err_o
);

   localparam int T  = CLKFREQ / BAUD;
   localparam int CW = $clog2(T) + 1;
   localparam logic [CW-1:0] T_FULL = CW'(T);
   localparam logic [CW-1:0] T_HALF = CW'(T / 2);

   logic            meta_q, rd_s_q;
   rx_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [6:0]      shift_q, shift_d;
   logic [6:0]      char_q, char_d;
   logic            char_valid_q, char_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            tick_s;

   // Synchroniser idles high so reset never looks like a start edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         rd_s_q <= 1'b1;
      end else begin
         meta_q <= rd_i;
         rd_s_q <= meta_q;
      end
   end

   // Receiver state and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= RX_IDLE;
         cnt_q        <= '0;
         bit_q        <= 3'd0;
         shift_q      <= 7'd0;
         char_q       <= 7'd0;
         char_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         char_q       <= char_d;
         char_valid_q <= char_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign tick_s = (cnt_q <= CW'(1));

   // Next-state logic; every sample point reloads the full bit period so no drift accrues.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      char_d       = char_q;
      char_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!rd_s_q) begin
               cnt_d   = T_HALF;
               state_d = RX_START;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (tick_s) begin
               if (!rd_s_q) begin
                  cnt_d   = T_FULL;
                  bit_d   = 3'd0;
                  state_d = RX_DATA;
               end else begin
                  state_d = RX_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RX_DATA: begin
            if (tick_s) begin
               shift_d = {rd_s_q, shift_q[6:1]};
               cnt_d   = T_FULL;
               if (bit_q == 3'd6) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RX_STOP: begin
            if (tick_s) begin
               if (rd_s_q) begin
                  char_d       = shift_q;
                  char_valid_d = 1'b1;
                  state_d      = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = RX_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RX_WAIT_HIGH: begin
            if (rd_s_q) begin
               state_d = RX_IDLE;
            end else begin
               state_d = RX_WAIT_HIGH;
            end
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   assign char_o       = char_q;
   assign char_valid_o = char_valid_q;
   assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/msmouse_serial_decoder.sv
// Microsoft serial-mouse decoder: reassembles 3-byte 7N1 packets into signed
// deltas and button states, presented through a valid/ready report register.
module msmouse_serial_decoder
   import msmouse_pkg::*;
#(
   parameter int CLKFREQ = 50_000_000,
   parameter int BAUD    = 1_200
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rd_i,
   input  logic       rts_i,
   output logic       pkt_valid_o,
   input  logic       pkt_ready_i,
   output logic       btn_l_o,
   output logic       btn_r_o,
   output logic [7:0] dx_o,
   output logic [7:0] dy_o,
   output logic       id_seen_o,
   output logic       frame_err_o,
   output logic       overrun_o
);

   logic [6:0] char_s;
   logic       char_valid_s;
   logic       frame_err_s;

   asm_state_e asm_q, asm_d;
   logic [5:0] b1_q, b1_d;
   logic [5:0] x_q, x_d;
   report_t    rep_q, rep_d;
   report_t    new_rep_s;
   logic       valid_q, valid_d;
   logic       id_q, id_d;
   logic       ovr_q, ovr_d;
   logic       complete_s;
   logic       hs_s;

   uart7n1_rx #(
      .CLKFREQ (CLKFREQ),
      .BAUD    (BAUD)
   ) u_rx (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .rd_i         (rd_i),
      .char_o       (char_s),
      .char_valid_o (char_valid_s),
      .frame_err_o  (frame_err_s)
   );

   // Assembler state, byte latches and output report register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         asm_q   <= P_B1;
         b1_q    <= 6'd0;
         x_q     <= 6'd0;
         rep_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         asm_q   <= asm_d;
         b1_q    <= b1_d;
         x_q     <= x_d;
         rep_q   <= rep_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         ovr_q   <= ovr_d;
      end
   end

   assign hs_s = valid_q & pkt_ready_i;

   always_comb begin
      new_rep_s.btn_l = b1_q[5];
      new_rep_s.btn_r = b1_q[4];
      new_rep_s.dx    = {b1_q[1:0], x_q};
      new_rep_s.dy    = {b1_q[3:2], char_s[5:0]};
   end

   // Packet assembly; any sync-bit character restarts a packet, the ID byte resets to idle.
   always_comb begin
      asm_d      = asm_q;
      b1_d       = b1_q;
      x_d        = x_q;
      complete_s = 1'b0;
      id_d       = char_valid_s && (char_s == MS_ID_CHAR);
      if (frame_err_s || !rts_i) begin
         asm_d = P_B1;
      end else if (char_valid_s) begin
         if (char_s == MS_ID_CHAR) begin
            asm_d = P_B1;
         end else if (is_first_byte(char_s)) begin
            b1_d  = char_s[5:0];
            asm_d = P_B2;
         end else begin
            case (asm_q)
               P_B2: begin
                  x_d   = char_s[5:0];
                  asm_d = P_B3;
               end
               P_B3: begin
                  complete_s = 1'b1;
                  asm_d      = P_B1;
               end
               P_B1: begin
                  asm_d = P_B1;
               end
               default: begin
                  asm_d = P_B1;
               end
            endcase
         end
      end else begin
         asm_d = asm_q;
      end
   end

   // Report register: a same-cycle handshake frees the slot for the new packet.
   always_comb begin
      rep_d   = rep_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (complete_s) begin
         if (!valid_q || hs_s) begin
            rep_d   = new_rep_s;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (hs_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   assign pkt_valid_o = valid_q;
   assign btn_l_o     = rep_q.btn_l;
   assign btn_r_o     = rep_q.btn_r;
   assign dx_o        = rep_q.dx;
   assign dy_o        = rep_q.dy;
   assign id_seen_o   = id_q;
   assign frame_err_o = frame_err_s;
   assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_msmouse_serial_decoder.sv
// Directed bench for msmouse_serial_decoder with T = 10 clocks per bit.
module tb_msmouse_serial_decoder;

   localparam int T = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rd = 1'b1;
   logic       rts = 1'b1;
   logic       ready = 1'b0;
   logic       pkt_valid, btn_l, btn_r, id_seen, frame_err, overrun;
   logic [7:0] dx, dy;

   int checks = 0;
   int failures = 0;
   int id_cnt = 0, fe_cnt = 0, ov_cnt = 0, rise_cnt = 0;
   logic pv_prev = 1'b0;

   msmouse_serial_decoder #(
      .CLKFREQ (12_000),
      .BAUD    (1_200)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .rd_i        (rd),
      .rts_i       (rts),
      .pkt_valid_o (pkt_valid),
      .pkt_ready_i (ready),
      .btn_l_o     (btn_l),
      .btn_r_o     (btn_r),
      .dx_o        (dx),
      .dy_o        (dy),
      .id_seen_o   (id_seen),
      .frame_err_o (frame_err),
      .overrun_o   (overrun)
   );

   always #5 clk = ~clk;

   // Count pulse-high cycles and report arrivals.
   always @(negedge clk) begin
      if (id_seen)   id_cnt <= id_cnt + 1;
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
      if (pkt_valid && !pv_prev) rise_cnt <= rise_cnt + 1;
      pv_prev <= pkt_valid;
   end

   typedef struct {
      int              n;
      logic [4:0][6:0] ch;
      int              exp_id;
      int              exp_pkt;
      logic            l;
      logic            r;
      logic [7:0]      dx;
      logic [7:0]      dy;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mk(input int n, input logic [6:0] c0, c1, c2, c3, c4,
                               input int id, input int pkt, input logic l, r,
                               input logic [7:0] x, y);
      vec_t v;
      v.n = n; v.ch = {c4, c3, c2, c1, c0};
      v.exp_id = id; v.exp_pkt = pkt; v.l = l; v.r = r; v.dx = x; v.dy = y;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic send_bit(input logic b);
      rd = b;
      repeat (T) tick();
   endtask

   // stop_ok=0 holds the line low 3T after the data; hs raises ready in the completion cycle.
   task automatic send_char(input logic [6:0] c, input logic stop_ok, input logic hs);
      send_bit(1'b0);
      for (int i = 0; i < 7; i++) send_bit(c[i]);
      if (!stop_ok) begin
         rd = 1'b0;
         repeat (3 * T) tick();
         rd = 1'b1;
         repeat (2 * T) tick();
      end else if (hs) begin
         rd = 1'b1;
         repeat (8) tick();
         ready = 1'b1;
         tick();
         ready = 1'b0;
         repeat (T - 9) tick();
      end else begin
         send_bit(1'b1);
      end
   endtask

   task automatic send_pkt(input logic [6:0] a, b, c);
      send_char(a, 1'b1, 1'b0);
      send_char(b, 1'b1, 1'b0);
      send_char(c, 1'b1, 1'b0);
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      tick();
      ready = 1'b0;
   endtask

   task automatic chk_rep(input string tag, input logic l, r, input logic [7:0] x, y);
      chk({tag, "_valid"}, 32'(pkt_valid), 32'd1);
      chk({tag, "_btn_l"}, 32'(btn_l), 32'(l));
      chk({tag, "_btn_r"}, 32'(btn_r), 32'(r));
      chk({tag, "_dx"}, 32'(dx), 32'(x));
      chk({tag, "_dy"}, 32'(dy), 32'(y));
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int id0, r0;
      string tag;
      tag = $sformatf("vec%0d", idx);
      id0 = id_cnt;
      r0  = rise_cnt;
      for (int i = 0; i < v.n; i++) send_char(v.ch[i], 1'b1, 1'b0);
      repeat (3) tick();
      sample();
      chk({tag, "_id"}, 32'(id_cnt - id0), 32'(v.exp_id));
      chk({tag, "_pkts"}, 32'(rise_cnt - r0), 32'(v.exp_pkt));
      if (v.exp_pkt != 0) begin
         chk_rep(tag, v.l, v.r, v.dx, v.dy);
      end else begin
         chk({tag, "_novalid"}, 32'(pkt_valid), 32'd0);
      end
      pulse_ready();
      sample();
      chk({tag, "_cleared"}, 32'(pkt_valid), 32'd0);
   endtask

   initial begin
      int f0, r0, o0;
      vecs[0] = mk(1, 7'h4D, 7'h00, 7'h00, 7'h00, 7'h00, 1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      vecs[1] = mk(3, 7'h60, 7'h05, 7'h3E, 7'h00, 7'h00, 0, 1, 1'b1, 1'b0, 8'h05, 8'h3E);
      vecs[2] = mk(3, 7'h4F, 7'h3F, 7'h00, 7'h00, 7'h00, 0, 1, 1'b0, 1'b0, 8'hFF, 8'hC0);
      vecs[3] = mk(5, 7'h40, 7'h01, 7'h50, 7'h02, 7'h03, 0, 1, 1'b0, 1'b1, 8'h02, 8'h03);
      vecs[4] = mk(4, 7'h60, 7'h4D, 7'h05, 7'h3E, 7'h00, 1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      vecs[5] = mk(3, 7'h6A, 7'h2A, 7'h15, 7'h00, 7'h00, 0, 1, 1'b1, 1'b0, 8'hAA, 8'h95);

      repeat (3) tick();
      sample();
      chk("reset_outputs", 32'({pkt_valid, btn_l, btn_r, dx, dy, id_seen, frame_err, overrun}), 32'd0);
      rst_n = 1'b1;
      repeat (2 * T) tick();

      for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

      // Bad stop bit mid-packet: one frame_err, assembler back in P_B1.
      send_char(7'h60, 1'b1, 1'b0);
      send_char(7'h05, 1'b1, 1'b0);
      f0 = fe_cnt;
      r0 = rise_cnt;
      send_char(7'h00, 1'b0, 1'b0);
      sample();
      chk("ferr_pulses", 32'(fe_cnt - f0), 32'd1);
      send_char(7'h3E, 1'b1, 1'b0);
      sample();
      chk("ferr_no_pkt", 32'(rise_cnt - r0), 32'd0);
      chk("ferr_novalid", 32'(pkt_valid), 32'd0);
      send_pkt(7'h4F, 7'h3F, 7'h00);
      sample();
      chk("ferr_recover_pkts", 32'(rise_cnt - r0), 32'd1);
      chk_rep("ferr_recover", 1'b0, 1'b0, 8'hFF, 8'hC0);
      pulse_ready();

      // RTS low blocks assembly but keeps the pending report.
      send_pkt(7'h60, 7'h05, 7'h3E);
      rts = 1'b0;
      o0 = ov_cnt;
      send_pkt(7'h50, 7'h02, 7'h03);
      sample();
      chk("rts_no_overrun", 32'(ov_cnt - o0), 32'd0);
      chk_rep("rts_hold", 1'b1, 1'b0, 8'h05, 8'h3E);
      rts = 1'b1;
      pulse_ready();
      sample();
      chk("rts_cleared", 32'(pkt_valid), 32'd0);

      // Overrun: second packet dropped, first retained.
      o0 = ov_cnt;
      send_pkt(7'h60, 7'h05, 7'h3E);
      send_pkt(7'h50, 7'h02, 7'h03);
      sample();
      chk("ovr_pulses", 32'(ov_cnt - o0), 32'd1);
      chk_rep("ovr_keep", 1'b1, 1'b0, 8'h05, 8'h3E);
      pulse_ready();
      sample();
      chk("ovr_cleared", 32'(pkt_valid), 32'd0);

      // Handshake in the completion cycle loads the new report without overrun.
      o0 = ov_cnt;
      send_pkt(7'h60, 7'h05, 7'h3E);
      send_char(7'h50, 1'b1, 1'b0);
      send_char(7'h02, 1'b1, 1'b0);
      send_char(7'h03, 1'b1, 1'b1);
      sample();
      chk("hs_no_overrun", 32'(ov_cnt - o0), 32'd0);
      chk_rep("hs_load", 1'b0, 1'b1, 8'h02, 8'h03);

      // Reset in the middle of a character with a report pending.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst_n = 1'b0;
      rd = 1'b1;
      sample();
      chk("midreset_outputs", 32'({pkt_valid, btn_l, btn_r, dx, dy, id_seen, frame_err, overrun}), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2 * T) tick();
      send_pkt(7'h6A, 7'h2A, 7'h15);
      sample();
      chk_rep("post_reset", 1'b1, 1'b0, 8'hAA, 8'h95);
      pulse_ready();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
